// File: rtl/predistort_taps_loader_pkg.sv
// Shared definitions for the predistortion tap loader.
//   SR_TAP_DATA / SR_TAP_CTRL : settings-bus offsets from SR_BASE
//   CTRL_START_BIT / CTRL_CLEAR_BIT : bit positions in the control word
//   state_t : streamer FSM encoding
package predistort_taps_loader_pkg;

   localparam logic [7:0] SR_TAP_DATA = 8'd0;
   localparam logic [7:0] SR_TAP_CTRL = 8'd1;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_CLEAR_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

endpackage

// File: rtl/predistort_taps_loader_ram_2port.sv
// Simple dual-port tap RAM, 2^DEPTH x WIDTH.
//   wr_en/wr_addr/wr_data : write port (settings side)
//   rd_en/rd_addr/rd_data : read port (streamer side), 1-cycle latency;
//                           rd_data holds its value while rd_en is low.
// The storage array is deliberately not reset so tables survive a reset;
// only the read-data register is cleared.
module predistort_taps_loader_ram_2port
   import predistort_taps_loader_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [DEPTH-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [DEPTH-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   localparam int N = 1 << DEPTH;

   logic [WIDTH-1:0] mem [N];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/predistort_taps_loader.sv
// Predistortion tap loader: taps are written one word at a time over the
// settings bus into a tap RAM, then streamed out as an AXI-stream burst of
// 2^DEPTH words on a start command.
//   set_stb/set_addr/set_data : settings bus write
//   taps_tdata/tvalid/tlast/tready : tap stream to the predistorter
//   busy    : transfer in progress
//   done    : one-cycle pulse after the final tap handshake
//   wr_drop : one-cycle pulse when a tap write arrives while busy
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | waiting for start; tap writes accepted
//   ST_PRIME | first RAM read in flight (rd_ptr = 0)
//   ST_SEND  | RAM read register drives taps_tdata, beat rd_ptr
module predistort_taps_loader
   import predistort_taps_loader_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 7,
   parameter int SR_BASE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             set_stb,
   input  logic [7:0]       set_addr,
   input  logic [31:0]      set_data,
   output logic [WIDTH-1:0] taps_tdata,
   output logic             taps_tvalid,
   output logic             taps_tlast,
   input  logic             taps_tready,
   output logic             busy,
   output logic             done,
   output logic             wr_drop
);

   localparam logic [7:0] ADDR_DATA = 8'(SR_BASE) + SR_TAP_DATA;
   localparam logic [7:0] ADDR_CTRL = 8'(SR_BASE) + SR_TAP_CTRL;

   state_t           state, state_nx;
   logic [DEPTH-1:0] wr_ptr;
   logic [DEPTH-1:0] rd_ptr;
   logic [DEPTH-1:0] rd_addr;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             hit_data, hit_ctrl, start_req, clear_req, wr_en;
   logic             handshake, last_beat;
   logic             unused_set_data;

   assign unused_set_data = ^set_data;

   assign hit_data  = set_stb && (set_addr == ADDR_DATA);
   assign hit_ctrl  = set_stb && (set_addr == ADDR_CTRL);
   assign start_req = hit_ctrl && set_data[CTRL_START_BIT];
   assign clear_req = hit_ctrl && set_data[CTRL_CLEAR_BIT];
   assign wr_en     = hit_data && !busy;

   assign busy        = (state != ST_IDLE);
   assign taps_tvalid = (state == ST_SEND);
   assign last_beat   = (rd_ptr == {DEPTH{1'b1}});
   assign taps_tlast  = taps_tvalid && last_beat;
   assign handshake   = taps_tvalid && taps_tready;
   // The RAM read register doubles as the output register: it only
   // advances on a handshake, so stalls hold the beat without a skid.
   assign taps_tdata  = rd_data;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      rd_addr  = rd_ptr;
      unique case (state)
         ST_IDLE: begin
            if (start_req) state_nx = ST_PRIME;
         end
         ST_PRIME: begin
            rd_en    = 1'b1;
            state_nx = ST_SEND;
         end
         ST_SEND: begin
            if (handshake) begin
               if (last_beat) begin
                  state_nx = ST_IDLE;
               end else begin
                  // Prefetch the next word so tready-high streams without bubbles.
                  rd_en   = 1'b1;
                  rd_addr = rd_ptr + 1'b1;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
      end else if (state == ST_IDLE && start_req) begin
         rd_ptr <= '0;
      end else if (state == ST_SEND && handshake && !last_beat) begin
         rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Clear and data writes live at different addresses, so never coincide;
   // clear is honoured even mid-transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         wr_ptr <= '0;
      else if (clear_req) wr_ptr <= '0;
      else if (wr_en)     wr_ptr <= wr_ptr + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done    <= 1'b0;
         wr_drop <= 1'b0;
      end else begin
         done    <= (state == ST_SEND) && handshake && last_beat;
         wr_drop <= hit_data && busy;
      end
   end

   predistort_taps_loader_ram_2port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (set_data[WIDTH-1:0]),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: doc/predistort_taps_loader.md
PREDISTORT_TAPS_LOADER -- requirements
Module: predistort_taps_loader

Interface
REQ-001 Parameter WIDTH, 16, tap word width in bits.
REQ-002 Parameter DEPTH, 7, log2 of tap count; N = 2^DEPTH taps.
REQ-003 Parameter SR_BASE, 0, settings-bus base address.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 set_stb  in  1  settings write strobe, one cycle.
REQ-007 set_addr  in  8  settings address.
REQ-008 set_data  in  32  settings data.
REQ-009 taps_tdata  out  WIDTH  tap word to predistorter.
REQ-010 taps_tvalid  out  1  AXI-stream valid.
REQ-011 taps_tlast  out  1  high on the N-th (final) tap only.
REQ-012 taps_tready  in  1  AXI-stream ready.
REQ-013 busy  out  1  high while a table transfer is in progress.
REQ-014 done  out  1  one-cycle pulse after the final tap handshake.
REQ-015 wr_drop  out  1  one-cycle pulse when a tap write is discarded.

Function
REQ-016 Tap RAM: N x WIDTH, written from the settings bus, read sequentially for streaming.
REQ-017 Write at SR_BASE+0: set_data[WIDTH-1:0] goes to RAM[wr_ptr]; wr_ptr increments mod N (N-1 -> 0).
REQ-018 Write at SR_BASE+1: bit0 = start, bit1 = clear wr_ptr to 0; both bits set: clear applied, start applied the same cycle.
REQ-019 Other addresses: ignored, no state change.
REQ-020 FSM states IDLE, PRIME, SEND.
REQ-021 IDLE -> PRIME on start; rd_ptr <- 0; RAM read issued.
REQ-022 PRIME -> SEND after exactly 1 cycle (RAM read latency 1); taps_tvalid rises on the first SEND cycle, i.e. 2 cycles after the start strobe.
REQ-023 SEND: taps_tdata = RAM[k] for the k-th beat (k = 0..N-1); handshake = tvalid & tready.
REQ-024 tready low: tdata, tlast, tvalid held stable; no beat lost or duplicated.
REQ-025 tready held high: one beat per cycle, no bubbles (prefetch / one-entry skid).
REQ-026 taps_tlast high only on beat N-1; SEND -> IDLE on its handshake; done pulses the following cycle.
REQ-027 busy = 1 in PRIME and SEND, 0 in IDLE.
REQ-028 Start while busy: ignored.
REQ-029 Tap write (SR_BASE+0) while busy: discarded, RAM and wr_ptr unchanged, wr_drop pulses next cycle.
REQ-030 Clear (SR_BASE+1 bit1) while busy: applied to wr_ptr; transfer unaffected.
REQ-031 Write count not checked: start always streams all N entries, including unwritten ones (RAM contents undefined after power-up).

Reset
REQ-032 reset low: FSM -> IDLE, wr_ptr = 0, rd_ptr = 0, taps_tvalid = 0, taps_tlast = 0, taps_tdata = 0, busy = 0, done = 0, wr_drop = 0.
REQ-033 RAM contents not reset; tables written before reset are still readable after it.
REQ-034 Reset mid-transfer: stream aborts immediately, no tlast issued; next start streams from tap 0.

Structure
REQ-035 Shared package holds SR offset constants (SR_TAP_DATA = 0, SR_TAP_CTRL = 1), control bit indices and the FSM state encoding.
REQ-036 One sub-module: ram_2port (WIDTH x N, write port from settings, read port to streamer, 1-cycle read latency).

Verification
REQ-037 Write N=128 taps 0x0000..0x007F, start, tready=1 -> 128 contiguous beats, data 0x0000..0x007F, tlast on beat 127 only, done one cycle later, first tvalid 2 cycles after start.
REQ-038 Same table, tready toggling 1-0-1-0 plus a 10-cycle low burst at beat 64 -> identical 128-word sequence, tdata stable whenever tvalid & !tready.
REQ-039 Write 0x1234 during SEND and issue a second start -> wr_drop pulses once, stream unchanged, RAM[wr_ptr] unchanged, no second transfer.
REQ-040 Write 130 taps (values 1..130) -> RAM[0] = 129, RAM[1] = 130, RAM[2..127] = 3..128 (wrap); clear bit then write 0xAAAA -> RAM[0] = 0xAAAA.
REQ-041 Assert reset at beat 50 -> tvalid 0 asynchronously, busy 0, no tlast; after release, start -> full 128 beats from tap 0 with the pre-reset table contents.
